// File: rtl/mem_arbiter.sv
// Two-master, single-slave memory arbiter: instruction and data buses share one 16-bit word port.
// The data bus has priority, but a data burst limit guarantees that instruction prefetch makes progress.
module mem_arbiter #(
    parameter int unsigned DATA_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] instr_m_addr,
    output logic [15:0] instr_m_data_in,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    input  logic [18:0] data_m_addr,
    output logic [15:0] data_m_data_in,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    output logic        data_m_ack,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic [18:0] q_m_addr,
    input  logic [15:0] q_m_data_in,
    output logic [15:0] q_m_data_out,
    output logic        q_m_access,
    input  logic        q_m_ack,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel,
    output logic        q_grant_data
);

    typedef enum logic [1:0] {IDLE, SERVE_INSTR, SERVE_DATA} state_t;

    localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

    state_t      state_q, state_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [1:0]  bsel_q, bsel_d;
    logic        access_q, access_d;
    logic [3:0]  burst_q, burst_d;
    logic        gdata_q, gdata_d;
    logic        data_wins;

    assign instr_m_data_in = q_m_data_in;
    assign data_m_data_in  = q_m_data_in;

    assign q_m_addr     = addr_q;
    assign q_m_data_out = wdata_q;
    assign q_m_wr_en    = wr_q;
    assign q_m_bytesel  = bsel_q;
    assign q_m_access   = access_q;
    assign q_grant_data = gdata_q;

    // Data loses a simultaneous request only once the burst limit is reached.
    assign data_wins = data_m_access && (!instr_m_access || (burst_q != BURST_MAX));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        bsel_d      = bsel_q;
        access_d    = access_q;
        burst_d     = burst_q;
        gdata_d     = gdata_q;
        instr_m_ack = 1'b0;
        data_m_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_wins) begin
                    state_d  = SERVE_DATA;
                    access_d = 1'b1;
                    addr_d   = data_m_addr;
                    wdata_d  = data_m_data_out;
                    wr_d     = data_m_wr_en;
                    bsel_d   = data_m_bytesel;
                    gdata_d  = 1'b1;
                    if (!instr_m_access) begin
                        burst_d = 4'd0;
                    end else if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + 4'd1;
                    end
                end else if (instr_m_access) begin
                    state_d  = SERVE_INSTR;
                    access_d = 1'b1;
                    addr_d   = instr_m_addr;
                    wdata_d  = 16'h0000;
                    wr_d     = 1'b0;
                    bsel_d   = 2'b11;
                    gdata_d  = 1'b0;
                    burst_d  = 4'd0;
                end
            end
            SERVE_INSTR: begin
                if (q_m_ack) begin
                    instr_m_ack = reset;
                    access_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            SERVE_DATA: begin
                if (q_m_ack) begin
                    data_m_ack = reset;
                    access_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                access_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= 19'h0;
            wdata_q  <= 16'h0;
            wr_q     <= 1'b0;
            bsel_q   <= 2'b00;
            access_q <= 1'b0;
            burst_q  <= 4'd0;
            gdata_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            bsel_q   <= bsel_d;
            access_q <= access_d;
            burst_q  <= burst_d;
            gdata_q  <= gdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed master requests push the expected memory transactions,
// and a monitor pops and compares them whenever a master ack appears.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] instr_m_addr;
    logic [15:0] instr_m_data_in;
    logic        instr_m_access;
    logic        instr_m_ack;
    logic [18:0] data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic        data_m_access;
    logic        data_m_ack;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;
    logic [18:0] q_m_addr;
    logic [15:0] q_m_data_in;
    logic [15:0] q_m_data_out;
    logic        q_m_access;
    logic        q_m_ack;
    logic        q_m_wr_en;
    logic [1:0]  q_m_bytesel;
    logic        q_grant_data;

    mem_arbiter #(.DATA_BURST_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .instr_m_addr(instr_m_addr), .instr_m_data_in(instr_m_data_in),
        .instr_m_access(instr_m_access), .instr_m_ack(instr_m_ack),
        .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
        .data_m_data_out(data_m_data_out), .data_m_access(data_m_access),
        .data_m_ack(data_m_ack), .data_m_wr_en(data_m_wr_en),
        .data_m_bytesel(data_m_bytesel),
        .q_m_addr(q_m_addr), .q_m_data_in(q_m_data_in), .q_m_data_out(q_m_data_out),
        .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
        .q_m_bytesel(q_m_bytesel), .q_grant_data(q_grant_data)
    );

    always #5 clk = ~clk;

    // Memory model: acks after mem_lat wait cycles; ack_force injects a stray ack.
    int   mem_lat = 0;
    int   lat_cnt = 0;
    logic ack_force = 1'b0;
    logic [15:0] rdata_v = 16'h0;

    assign q_m_ack     = (q_m_access && (lat_cnt >= mem_lat)) || ack_force;
    assign q_m_data_in = rdata_v;

    always @(posedge clk) begin
        if (q_m_access && !q_m_ack) lat_cnt <= lat_cnt + 1;
        else                         lat_cnt <= 0;
    end

    typedef struct {
        logic        is_data;
        logic [18:0] addr;
        logic        wr;
        logic [1:0]  bsel;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic is_data, input logic [18:0] addr, input logic wr,
                        input logic [1:0] bsel, input logic [15:0] wdata, input logic [15:0] rdata);
        exp_t e;
        e.is_data = is_data; e.addr = addr; e.wr = wr;
        e.bsel = bsel; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Monitor: memory-side fields must match the pending transaction for every access cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset && q_m_access && (sb.size() > 0)) begin
            e = sb[0];
            chk("q_m_addr",     {13'h0, q_m_addr},     {13'h0, e.addr});
            chk("q_m_wr_en",    {31'h0, q_m_wr_en},    {31'h0, e.wr});
            chk("q_m_bytesel",  {30'h0, q_m_bytesel},  {30'h0, e.bsel});
            chk("q_m_data_out", {16'h0, q_m_data_out}, {16'h0, e.wdata});
            chk("q_grant_data", {31'h0, q_grant_data}, {31'h0, e.is_data});
        end
        if (instr_m_ack || data_m_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'h0, instr_m_ack, data_m_ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_master", {31'h0, data_m_ack},  {31'h0, e.is_data});
                chk("ack_both",   {31'h0, instr_m_ack & data_m_ack}, 32'h0);
                chk("rdata", {16'h0, (e.is_data ? data_m_data_in : instr_m_data_in)}, {16'h0, e.rdata});
            end
        end
    end

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(instr_m_ack || data_m_ack) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL %s timeout waiting for ack actual=none required=ack", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_access"},  {31'h0, q_m_access},   32'h0);
        chk({name, "_addr"},    {13'h0, q_m_addr},     32'h0);
        chk({name, "_wr"},      {31'h0, q_m_wr_en},    32'h0);
        chk({name, "_bsel"},    {30'h0, q_m_bytesel},  32'h0);
        chk({name, "_dout"},    {16'h0, q_m_data_out}, 32'h0);
        chk({name, "_gdata"},   {31'h0, q_grant_data}, 32'h0);
        chk({name, "_acks"},    {30'h0, instr_m_ack, data_m_ack}, 32'h0);
    endtask

    initial begin
        int n;
        int pat[5];
        pat = '{1, 0, 1, 0, 1};
        reset = 1'b0;
        instr_m_addr = 19'h0; instr_m_access = 1'b0;
        data_m_addr = 19'h0; data_m_data_out = 16'h0; data_m_access = 1'b0;
        data_m_wr_en = 1'b0; data_m_bytesel = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Instruction read
        mem_lat = 1; rdata_v = 16'hBEEF;
        instr_m_addr = 19'h0_0100; instr_m_access = 1'b1;
        push(1'b0, 19'h0_0100, 1'b0, 2'b11, 16'h0, 16'hBEEF);
        wait_ack("instr_read");
        instr_m_access = 1'b0;
        @(negedge clk);
        chk("instr_bubble_access", {31'h0, q_m_access}, 32'h0);
        @(posedge clk); #1;

        // Data write held over a 3-cycle wait
        mem_lat = 3; rdata_v = 16'h1111;
        data_m_addr = 19'h1_2345; data_m_data_out = 16'hA55A;
        data_m_wr_en = 1'b1; data_m_bytesel = 2'b01; data_m_access = 1'b1;
        push(1'b1, 19'h1_2345, 1'b1, 2'b01, 16'hA55A, 16'h1111);
        wait_ack("data_write");
        data_m_access = 1'b0; data_m_wr_en = 1'b0;
        @(posedge clk); #1;

        // Both masters request continuously: D,D,D,D,I repeating
        mem_lat = 0; rdata_v = 16'h2222;
        instr_m_addr = 19'h0_0200; data_m_addr = 19'h0_0300;
        data_m_bytesel = 2'b10; data_m_data_out = 16'h0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push(1'b1, 19'h0_0300, 1'b0, 2'b10, 16'h0, 16'h2222);
            push(1'b0, 19'h0_0200, 1'b0, 2'b11, 16'h0, 16'h2222);
        end
        instr_m_access = 1'b1; data_m_access = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        instr_m_access = 1'b0; data_m_access = 1'b0;
        chk("starvation_drained", sb.size(), 32'h0);
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("starvation_idle", {31'h0, q_m_access}, 32'h0);

        // Stray ack while idle
        @(posedge clk); #1;
        ack_force = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack_acks",   {30'h0, instr_m_ack, data_m_ack}, 32'h0);
            chk("idle_ack_access", {31'h0, q_m_access}, 32'h0);
        end
        @(posedge clk); #1;
        ack_force = 1'b0;
        @(negedge clk);
        chk("idle_ack_after", {31'h0, q_m_access}, 32'h0);

        // Reset in the middle of a data transfer, with a coincident ack
        @(posedge clk); #1;
        mem_lat = 20;
        data_m_addr = 19'h0_0777; data_m_wr_en = 1'b1; data_m_bytesel = 2'b11;
        data_m_data_out = 16'h1234; data_m_access = 1'b1;
        n = 0;
        @(negedge clk);
        while (!q_m_access && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_granted", {31'h0, q_m_access}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0; ack_force = 1'b1;
        @(negedge clk);
        chk("abort_data_ack", {31'h0, data_m_ack}, 32'h0);
        @(posedge clk); #1;
        ack_force = 1'b0;
        data_m_addr = 19'h0_0555; data_m_wr_en = 1'b0; data_m_bytesel = 2'b11;
        data_m_data_out = 16'h0;
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        mem_lat = 0; rdata_v = 16'hC0DE;
        reset = 1'b1;
        push(1'b1, 19'h0_0555, 1'b0, 2'b11, 16'h0, 16'hC0DE);
        wait_ack("post_reset_data");
        data_m_access = 1'b0;
        @(posedge clk); #1;

        // Bubble: zero-wait memory, instr held high for 3 transfers
        mem_lat = 0; rdata_v = 16'h3333; instr_m_addr = 19'h0_0400;
        for (int k = 0; k < 3; k++) push(1'b0, 19'h0_0400, 1'b0, 2'b11, 16'h0, 16'h3333);
        instr_m_access = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bubble_access_%0d", i), {31'h0, q_m_access}, pat[i]);
        end
        @(posedge clk); #1;
        instr_m_access = 1'b0;
        repeat (3) @(posedge clk);
        chk("final_sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
